// File: rtl/pwm_capture.sv
// pwm_capture
//   Measures an incoming PWM waveform (high time and period) and recovers the
//   3-bit switch code of the generator that produced it (code = high - 1 when
//   the period matches EXP_PERIOD and the high time is 1..8 clocks).
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous, active-high reset
//   pwm_in     - asynchronous PWM input (synchronised internally)
//   high_cnt   - high cycles of the last completed period
//   period_cnt - length of the last completed period, in clocks
//   sw_code    - recovered switch code, updated only on in-spec measurements
//   valid      - one-cycle pulse when high_cnt/period_cnt update
//   err        - one-cycle pulse with valid when the measurement is out of spec
//   locked     - two consecutive in-spec measurements with equal codes
//   no_signal  - no awaited edge for TIMEOUT cycles
module pwm_capture #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 10,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic [2:0]       sw_code,
    output logic             valid,
    output logic             err,
    output logic             locked,
    output logic             no_signal
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] HIGH  = 2'd2;
    localparam logic [1:0] LOW   = 2'd3;

    localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] EXP  = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] HMAX = CNT_W'(8);

    logic             s1, s2, s3;
    logic [1:0]       prime;
    logic [1:0]       state;
    logic [CNT_W-1:0] pcnt, hcnt;
    logic [CNT_W-1:0] pcnt_inc, hcnt_inc;
    logic             rise, fall, tmo, tmo_evt, in_spec;
    logic             hist_ok;
    logic [2:0]       hist_code, new_code;

    always_comb begin
        rise     = s2 & ~s3;
        fall     = ~s2 & s3;
        pcnt_inc = (pcnt >= TMO) ? TMO : pcnt + ONE;
        hcnt_inc = (hcnt >= TMO) ? TMO : hcnt + ONE;
        tmo      = (pcnt_inc == TMO);
        // A rise accepted in ARMED or LOW takes priority over the timeout.
        tmo_evt  = tmo & ~(rise & ((state == ARMED) | (state == LOW)));
        in_spec  = (pcnt == EXP) && (hcnt >= ONE) && (hcnt <= HMAX);
        new_code = hcnt[2:0] - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            prime      <= '0;
            state      <= IDLE;
            pcnt       <= '0;
            hcnt       <= '0;
            high_cnt   <= '0;
            period_cnt <= '0;
            sw_code    <= '0;
            valid      <= 1'b0;
            err        <= 1'b0;
            locked     <= 1'b0;
            no_signal  <= 1'b0;
            hist_ok    <= 1'b0;
            hist_code  <= '0;
        end else begin
            s1    <= pwm_in;
            s2    <= s1;
            s3    <= s2;
            prime <= {prime[0], 1'b1};
            valid <= 1'b0;
            err   <= 1'b0;
            pcnt  <= pcnt_inc;
            if (tmo_evt)
                no_signal <= 1'b1;

            case (state)
                // The synchroniser clears on reset, so a high input would look
                // like a fresh rise; wait until s2 carries real input samples
                // before judging it low, so a partial high phase is rejected.
                IDLE: begin
                    if (prime[1] && !s2)
                        state <= ARMED;
                end
                ARMED: begin
                    if (rise) begin
                        pcnt      <= ONE;
                        hcnt      <= ONE;
                        no_signal <= 1'b0;
                        state     <= HIGH;
                    end
                end
                HIGH: begin
                    if (tmo_evt) begin
                        state   <= IDLE;
                        locked  <= 1'b0;
                        hist_ok <= 1'b0;
                    end else if (fall) begin
                        state <= LOW;
                    end else if (s2) begin
                        hcnt <= hcnt_inc;
                    end
                end
                default: begin // LOW
                    if (rise) begin
                        period_cnt <= pcnt;
                        high_cnt   <= hcnt;
                        valid      <= 1'b1;
                        pcnt       <= ONE;
                        hcnt       <= ONE;
                        state      <= HIGH;
                        if (in_spec) begin
                            sw_code   <= new_code;
                            locked    <= hist_ok && (hist_code == new_code);
                            hist_ok   <= 1'b1;
                            hist_code <= new_code;
                        end else begin
                            err     <= 1'b1;
                            locked  <= 1'b0;
                            hist_ok <= 1'b0;
                        end
                    end else if (tmo_evt) begin
                        state   <= IDLE;
                        locked  <= 1'b0;
                        hist_ok <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
//   Directed bench for pwm_capture. Inputs change on the falling edge; every
//   valid pulse is logged as {high, period, sw_code, err, locked} and the
//   scenario tasks compare the log and the flags against hand-derived values.
module tb_pwm_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pwm_in = 1'b0;
    logic [7:0] high_cnt, period_cnt;
    logic [2:0] sw_code;
    logic       valid, err, locked, no_signal;

    int passed = 0;
    int total  = 0;

    logic [20:0] q[$];

    pwm_capture #(.CNT_W(8), .EXP_PERIOD(10), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .pwm_in(pwm_in),
        .high_cnt(high_cnt), .period_cnt(period_cnt), .sw_code(sw_code),
        .valid(valid), .err(err), .locked(locked), .no_signal(no_signal)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (valid) q.push_back({high_cnt, period_cnt, sw_code, err, locked});

    function automatic logic [20:0] m(input int h, input int p, input int c,
                                      input int e, input int l);
        return {8'(h), 8'(p), 3'(c), 1'(e), 1'(l)};
    endfunction

    task automatic run(input int h, input int p, input int n);
        for (int j = 0; j < n; j++)
            for (int i = 0; i < p; i++) begin
                @(negedge clk);
                pwm_in = (i < h);
            end
    endtask

    task automatic do_reset();
        pwm_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        q.delete();
    endtask

    task automatic test_reset();
        pwm_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if ({high_cnt, period_cnt} !== 16'h0) $display("FAIL reset_cnts got %h want 0000", {high_cnt, period_cnt}); else passed++;
        total++; if (sw_code !== 3'd0) $display("FAIL reset_sw got %0d want 0", sw_code); else passed++;
        total++; if ({valid, err, locked, no_signal} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {valid, err, locked, no_signal}); else passed++;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        q.delete();
    endtask

    task automatic test_basic();
        run(3, 10, 3);
        total++; if (q.size() != 2) $display("FAIL basic_count got %0d want 2", q.size()); else passed++;
        if (q.size() >= 2) begin
            total++; if (q[0] !== m(3, 10, 2, 0, 0)) $display("FAIL basic_first got %h want %h", q[0], m(3, 10, 2, 0, 0)); else passed++;
            total++; if (q[1] !== m(3, 10, 2, 0, 1)) $display("FAIL basic_second got %h want %h", q[1], m(3, 10, 2, 0, 1)); else passed++;
        end
        q.delete();
    endtask

    task automatic test_sweep();
        logic [20:0] e;
        for (int h = 1; h <= 8; h++) run(h, 10, 3);
        // first entry is the trailing high-3 period of the previous scenario
        total++; if (q.size() != 24) $display("FAIL sweep_count got %0d want 24", q.size()); else passed++;
        if (q.size() == 24) begin
            total++; if (q[0] !== m(3, 10, 2, 0, 1)) $display("FAIL sweep_carry got %h want %h", q[0], m(3, 10, 2, 0, 1)); else passed++;
            for (int k = 1; k < 24; k++) begin
                int h = (k - 1) / 3 + 1;
                e = m(h, 10, h - 1, 0, ((k - 1) % 3) != 0);
                total++; if (q[k] !== e) $display("FAIL sweep_%0d got %h want %h", k, q[k], e); else passed++;
            end
        end
        q.delete();
    endtask

    task automatic test_change();
        logic [20:0] exp_v[6];
        run(5, 10, 3);
        run(7, 10, 3);
        exp_v = '{m(8, 10, 7, 0, 1), m(5, 10, 4, 0, 0), m(5, 10, 4, 0, 1),
                  m(5, 10, 4, 0, 1), m(7, 10, 6, 0, 0), m(7, 10, 6, 0, 1)};
        total++; if (q.size() != 6) $display("FAIL change_count got %0d want 6", q.size()); else passed++;
        if (q.size() == 6)
            for (int k = 0; k < 6; k++) begin
                total++; if (q[k] !== exp_v[k]) $display("FAIL change_%0d got %h want %h", k, q[k], exp_v[k]); else passed++;
            end
        q.delete();
    endtask

    task automatic test_out_of_spec();
        run(4, 12, 2);
        total++; if (q.size() != 2) $display("FAIL oos12_count got %0d want 2", q.size()); else passed++;
        if (q.size() == 2) begin
            total++; if (q[0] !== m(7, 10, 6, 0, 1)) $display("FAIL oos12_carry got %h want %h", q[0], m(7, 10, 6, 0, 1)); else passed++;
            total++; if (q[1] !== m(4, 12, 6, 1, 0)) $display("FAIL oos12_meas got %h want %h", q[1], m(4, 12, 6, 1, 0)); else passed++;
        end
        q.delete();
        run(9, 10, 2);
        total++; if (q.size() != 2) $display("FAIL oos9_count got %0d want 2", q.size()); else passed++;
        if (q.size() == 2) begin
            total++; if (q[0] !== m(4, 12, 6, 1, 0)) $display("FAIL oos9_carry got %h want %h", q[0], m(4, 12, 6, 1, 0)); else passed++;
            total++; if (q[1] !== m(9, 10, 6, 1, 0)) $display("FAIL oos9_meas got %h want %h", q[1], m(9, 10, 6, 1, 0)); else passed++;
        end
        q.delete();
    endtask

    task automatic test_timeout();
        run(3, 10, 3);
        q.delete();
        // rise sampled at edge 1, accepted at edge 3 (pcnt=1); pcnt hits 255 at edge 257
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (256) @(negedge clk);
        total++; if ({no_signal, locked} !== 2'b01) $display("FAIL tmo_before got %b want 01", {no_signal, locked}); else passed++;
        @(negedge clk);
        total++; if ({no_signal, locked} !== 2'b10) $display("FAIL tmo_at got %b want 10", {no_signal, locked}); else passed++;
        repeat (43) @(negedge clk);
        total++; if (no_signal !== 1'b1) $display("FAIL tmo_hold got %b want 1", no_signal); else passed++;
        total++; if (q.size() != 1) $display("FAIL tmo_count got %0d want 1", q.size()); else passed++;
        if (q.size() == 1) begin
            total++; if (q[0] !== m(3, 10, 2, 0, 1)) $display("FAIL tmo_last got %h want %h", q[0], m(3, 10, 2, 0, 1)); else passed++;
        end
        q.delete();
        // recovery: low gap, then a period of high 2
        pwm_in = 1'b0;
        repeat (5) @(negedge clk);
        pwm_in = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (no_signal !== 1'b1) $display("FAIL rec_pre got %b want 1", no_signal); else passed++;
        pwm_in = 1'b0;
        @(negedge clk);
        total++; if (no_signal !== 1'b0) $display("FAIL rec_clear got %b want 0", no_signal); else passed++;
        repeat (6) @(negedge clk);
        run(2, 10, 2);
        total++; if (q.size() != 2) $display("FAIL rec_count got %0d want 2", q.size()); else passed++;
        if (q.size() == 2) begin
            total++; if (q[0] !== m(2, 10, 1, 0, 0)) $display("FAIL rec_first got %h want %h", q[0], m(2, 10, 1, 0, 0)); else passed++;
            total++; if (q[1] !== m(2, 10, 1, 0, 1)) $display("FAIL rec_second got %h want %h", q[1], m(2, 10, 1, 0, 1)); else passed++;
        end
        q.delete();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        total++; if ({high_cnt, period_cnt, sw_code} !== 19'h0) $display("FAIL rmid_outs got %h want 0", {high_cnt, period_cnt, sw_code}); else passed++;
        total++; if ({valid, err, locked, no_signal} !== 4'b0) $display("FAIL rmid_flags got %b want 0000", {valid, err, locked, no_signal}); else passed++;
        repeat (2) @(negedge clk);
        pwm_in = 1'b0;
        repeat (6) @(negedge clk);
        run(4, 10, 3);
        total++; if (q.size() != 2) $display("FAIL rmid_count got %0d want 2", q.size()); else passed++;
        if (q.size() == 2) begin
            total++; if (q[0] !== m(4, 10, 3, 0, 0)) $display("FAIL rmid_first got %h want %h", q[0], m(4, 10, 3, 0, 0)); else passed++;
            total++; if (q[1] !== m(4, 10, 3, 0, 1)) $display("FAIL rmid_second got %h want %h", q[1], m(4, 10, 3, 0, 1)); else passed++;
        end
        q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_change();
        test_out_of_spec();
        test_timeout();
        test_reset_mid();
        do_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

- Measures an incoming PWM waveform, reporting its high time, period and the 3-bit switch code that produced it.
- Sits at the receiving end of the PWM link: the counterpart to the 10-cycle-period, 10–80 % duty generator driven by `sw[2:0]`.
- Used for loopback checking and remote duty readback.
- Recovers `sw` as `high_cnt - 1` when the measured waveform is in spec.

## Interface

Parameters:
- `CNT_W`, 8: width of the high and period counters.
- `EXP_PERIOD`, 10: expected PWM period in clocks. A measurement is in spec only when the period equals this value.
- `TIMEOUT`, 255: cycles without an awaited edge before `no_signal` asserts. Must be ≤ 2^CNT_W − 1.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `pwm_in` input 1: asynchronous PWM input.
- `high_cnt` output CNT_W: high cycles of the last completed period.
- `period_cnt` output CNT_W: length of the last completed period, in clocks.
- `sw_code` output 3: recovered switch code, updated only on in-spec measurements.
- `valid` output 1: one-cycle pulse when `high_cnt`/`period_cnt` update.
- `err` output 1: one-cycle pulse coincident with `valid` when the measurement is out of spec.
- `locked` output 1: two consecutive in-spec measurements with equal codes.
- `no_signal` output 1: timeout flag.

## Operation

Synchroniser and edge detect:
- `pwm_in` → `s1` → `s2`; `s3` = previous `s2`. All three reset to 0.
- `rise = s2 & !s3`; `fall = !s2 & s3`. Only `s2` is used downstream.

FSM states:
- IDLE (reset state): wait for `s2 == 0`, then go to ARMED. This rejects a partial high phase present at reset release.
- ARMED: on `rise`, load `pcnt = 1` and `hcnt = 1`, then go to HIGH.
- HIGH: each cycle `pcnt += 1` and `hcnt += 1` while `s2 = 1`. On `fall`, `pcnt += 1` only, then go to LOW.
- LOW: each cycle `pcnt += 1`. On `rise`, publish the measurement, reload `pcnt = 1` and `hcnt = 1`, then go to HIGH.

Publish:
- `period_cnt <= pcnt` and `high_cnt <= hcnt` (values before reload); `valid <= 1`.
- In spec means `period == EXP_PERIOD` and `1 ≤ high ≤ 8`:
  - Set `sw_code <= high - 1` and `err <= 0`.
  - `locked <= 1` if the previous publish was in spec with the same code; otherwise `locked <= 0`.
- Out of spec: `err <= 1`, `sw_code` holds, `locked <= 0`.

Counters:
- `pcnt` runs in all states and saturates at TIMEOUT. `hcnt` saturates at TIMEOUT.
- No wrap-around in either counter.

Timeout:
- When `pcnt` reaches TIMEOUT in any state, set `no_signal <= 1`.
- If the FSM is in HIGH or LOW, it goes to IDLE and clears `locked` and the in-spec history.
- `no_signal` clears on the next `rise` accepted in ARMED.
- A constant 0 % or 100 % input therefore ends in a timeout; no `valid` is produced.

Reset:
- `rst` in any state: FSM to IDLE. All counters, history and outputs go to 0, including `sw_code`, `high_cnt` and `period_cnt`.
- No `valid` is produced for a period interrupted by reset.

Simultaneous events:
- A `rise` in the same cycle that `pcnt` hits TIMEOUT: `rise` wins in ARMED and LOW, with publish and reload. The out-of-spec period then flags `err`.
- `rst` overrides everything.

## Timing

Input latency:
- A `pwm_in` transition sampled at edge N is visible as `rise`/`fall` during cycle [N+1, N+2).
- The FSM acts at edge N+2.
- `valid` is high for exactly one cycle, [N+2, N+3), aligned to the second rising edge of a measured period.

Output timing:
- All outputs are registered.
- `high_cnt`, `period_cnt`, `sw_code`, `err` and `locked` change only on the edge that raises `valid`. The exception is `locked`, which also drops on timeout.

Measurement cadence:
- The first `valid` after reset or timeout comes at the second accepted rise. For a 10-cycle PWM this is ≤ 22 cycles after reset release, with `pwm_in` low at release.
- Steady state: one `valid` every `period_cnt` cycles.

## Test plan

- **Basic measurement:** reset, then drive period 10, high 3 continuously → first `valid` with `high_cnt = 3`, `period_cnt = 10`, `sw_code = 2`, `err = 0`, `locked = 0`. Second `valid`: `locked = 1`.
- **Code sweep:** sweep high 1..8 at period 10, 3 periods each → `sw_code` 0..7. `locked` asserts on the second `valid` of each setting; `err` never pulses.
- **Mid-stream change:** change from high 5 to high 7 → one `valid` with `sw_code = 4` and `locked = 1`. Then `sw_code = 6` with `locked = 0`; the next `valid` gives `locked = 1`.
- **Out of spec:** period 12, high 4 → `valid` with `err = 1`, `period_cnt = 12`, `sw_code` unchanged, `locked = 0`. Also high 9 at period 10 → `err = 1`.
- **Timeout and recovery:** hold `pwm_in` high for 300 cycles → `no_signal = 1` exactly when `pcnt` reaches 255 after the last rise; FSM in IDLE, `locked = 0`. Resume period 10, high 2 → `no_signal = 0` at the first accepted rise; the next `valid` has `high_cnt = 2`.
- **Reset mid-period:** pulse `rst` for 1 cycle while `pwm_in` is high → all outputs 0, no `valid` from the partial high phase. The first `valid` after that reports the correct full high count and period.
